// File: rtl/torpedo_motion_if.sv
// Torpedo motion control/status bundle between game logic (master) and the
// torpedo motion controller (slave).
interface torpedo_motion_if;
    logic       fire;
    logic [9:0] launch_x;
    logic [9:0] launch_y;
    logic [1:0] dir;
    logic       hit;
    logic [9:0] Torpedo_X_Pos;
    logic [9:0] Torpedo_Y_Pos;
    logic [9:0] torpedo_stop;
    logic       ready;
    logic       blast;
    logic       miss;

    modport master (
        output fire, launch_x, launch_y, dir, hit,
        input  Torpedo_X_Pos, Torpedo_Y_Pos, torpedo_stop, ready, blast, miss
    );

    modport slave (
        input  fire, launch_x, launch_y, dir, hit,
        output Torpedo_X_Pos, Torpedo_Y_Pos, torpedo_stop, ready, blast, miss
    );
endinterface

// File: rtl/torpedo_motion.sv
// Per-frame torpedo motion controller: launch, fixed-direction flight,
// boundary exit, blast hold after a hit, and cooldown before re-launch.
// Optional macro TORPEDO_ACCEL_EN: step grows by 1 every 4 flying ticks,
// saturating at 2*STEP.
module torpedo_motion #(
    parameter int unsigned STEP            = 4,
    parameter int unsigned X_MIN           = 0,
    parameter int unsigned X_MAX           = 639,
    parameter int unsigned Y_MIN           = 0,
    parameter int unsigned Y_MAX           = 479,
    parameter int unsigned BLAST_FRAMES    = 8,
    parameter int unsigned COOLDOWN_FRAMES = 30,
    parameter int unsigned X_HOME          = 320,
    parameter int unsigned Y_HOME          = 240
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    torpedo_motion_if.slave  bus
);

    localparam int unsigned PW = 10;  // position width
    localparam int unsigned EW = 11;  // boundary arithmetic width
    localparam int unsigned CW = 8;   // frame counter width
    localparam int unsigned NW = 9;   // frame counter compare width

    typedef enum logic [1:0] {IDLE, FLYING, BLAST, COOLDOWN} state_t;

    state_t          state;
    logic [PW-1:0]   x_pos;
    logic [PW-1:0]   y_pos;
    logic [1:0]      dir_q;
    logic [CW-1:0]   frame_cnt;
    logic            frame_clk_d;
    logic            stop_q;
    logic            ready_q;
    logic            blast_q;
    logic            miss_q;

    logic            tick_c;
    logic            oob_c;
    logic [PW-1:0]   x_step_c;
    logic [PW-1:0]   y_step_c;
    logic [PW-1:0]   cur_step;

`ifdef TORPEDO_ACCEL_EN
    logic [PW-1:0]   step_q;
    logic [1:0]      accel_cnt;
    assign cur_step = step_q;
`else
    assign cur_step = PW'(STEP);
`endif

    // Rising edge of the frame indicator marks one frame.
    assign tick_c = frame_clk & ~frame_clk_d;

    // Limit a launch coordinate to the playfield so position never leaves it.
    function automatic logic [PW-1:0] clamp(input logic [PW-1:0] v,
                                            input int unsigned lo,
                                            input int unsigned hi);
        if (v < PW'(lo))      return PW'(lo);
        else if (v > PW'(hi)) return PW'(hi);
        else                  return v;
    endfunction

    // Next flight position and boundary test, 11-bit to avoid wrap.
    always_comb begin
        oob_c    = 1'b0;
        x_step_c = x_pos;
        y_step_c = y_pos;
        case (dir_q)
            2'd0: if (EW'(x_pos) + EW'(cur_step) > EW'(X_MAX)) oob_c = 1'b1;
                  else x_step_c = x_pos + cur_step;
            2'd1: if (EW'(x_pos) < EW'(X_MIN) + EW'(cur_step)) oob_c = 1'b1;
                  else x_step_c = x_pos - cur_step;
            2'd2: if (EW'(y_pos) + EW'(cur_step) > EW'(Y_MAX)) oob_c = 1'b1;
                  else y_step_c = y_pos + cur_step;
            default: if (EW'(y_pos) < EW'(Y_MIN) + EW'(cur_step)) oob_c = 1'b1;
                  else y_step_c = y_pos - cur_step;
        endcase
    end

    // State machine with registered position and status outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            x_pos       <= PW'(X_HOME);
            y_pos       <= PW'(Y_HOME);
            dir_q       <= 2'd0;
            frame_cnt   <= '0;
            frame_clk_d <= 1'b0;
            stop_q      <= 1'b1;
            ready_q     <= 1'b1;
            blast_q     <= 1'b0;
            miss_q      <= 1'b0;
`ifdef TORPEDO_ACCEL_EN
            step_q      <= PW'(STEP);
            accel_cnt   <= 2'd0;
`endif
        end else begin
            frame_clk_d <= frame_clk;
            miss_q      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.fire) begin
                        x_pos     <= clamp(bus.launch_x, X_MIN, X_MAX);
                        y_pos     <= clamp(bus.launch_y, Y_MIN, Y_MAX);
                        dir_q     <= bus.dir;
                        stop_q    <= 1'b0;
                        ready_q   <= 1'b0;
                        frame_cnt <= '0;
                        state     <= FLYING;
`ifdef TORPEDO_ACCEL_EN
                        step_q    <= PW'(STEP);
                        accel_cnt <= 2'd0;
`endif
                    end
                end
                FLYING: begin
                    if (bus.hit) begin
                        frame_cnt <= '0;
                        if (BLAST_FRAMES == 0) begin
                            stop_q <= 1'b1;
                            state  <= COOLDOWN;
                        end else begin
                            blast_q <= 1'b1;
                            state   <= BLAST;
                        end
                    end else if (tick_c) begin
                        if (oob_c) begin
                            stop_q    <= 1'b1;
                            miss_q    <= 1'b1;
                            frame_cnt <= '0;
                            state     <= COOLDOWN;
                        end else begin
                            x_pos <= x_step_c;
                            y_pos <= y_step_c;
`ifdef TORPEDO_ACCEL_EN
                            accel_cnt <= accel_cnt + 2'd1;
                            if (accel_cnt == 2'd3 && step_q < PW'(2 * STEP))
                                step_q <= step_q + PW'(1);
`endif
                        end
                    end
                end
                BLAST: begin
                    if (tick_c) begin
                        if (NW'(frame_cnt) + NW'(1) >= NW'(BLAST_FRAMES)) begin
                            blast_q   <= 1'b0;
                            stop_q    <= 1'b1;
                            frame_cnt <= '0;
                            state     <= COOLDOWN;
                        end else begin
                            frame_cnt <= frame_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    if (COOLDOWN_FRAMES == 0 ||
                        (tick_c && NW'(frame_cnt) + NW'(1) >= NW'(COOLDOWN_FRAMES))) begin
                        ready_q   <= 1'b1;
                        frame_cnt <= '0;
                        state     <= IDLE;
                    end else if (tick_c) begin
                        frame_cnt <= frame_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.Torpedo_X_Pos = x_pos;
    assign bus.Torpedo_Y_Pos = y_pos;
    assign bus.torpedo_stop  = {9'd0, stop_q};
    assign bus.ready         = ready_q;
    assign bus.blast         = blast_q;
    assign bus.miss          = miss_q;

endmodule

// File: tb/tb_torpedo_motion.sv
// Directed bench for torpedo_motion: default-parameter instance plus a
// zero-blast / zero-cooldown instance.
module tb_torpedo_motion;

    logic Clk = 1'b0;
    logic Reset;
    logic frame_clk;

    int n_pass  = 0;
    int n_total = 0;

    always #10 Clk = ~Clk;

    torpedo_motion_if bus_a ();
    torpedo_motion_if bus_b ();

    torpedo_motion dut_a (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .bus       (bus_a)
    );

    torpedo_motion #(.BLAST_FRAMES(0), .COOLDOWN_FRAMES(0)) dut_b (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .bus       (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One frame: frame_clk high for exactly one Clk edge.
    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge Clk) frame_clk = 1'b1;
            @(negedge Clk) frame_clk = 1'b0;
        end
    endtask

    task automatic launch_a(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d);
        @(negedge Clk);
        bus_a.fire = 1'b1; bus_a.launch_x = x; bus_a.launch_y = y; bus_a.dir = d;
        @(negedge Clk);
        bus_a.fire = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk) Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0;
        bus_a.fire = 1'b0; bus_a.launch_x = '0; bus_a.launch_y = '0; bus_a.dir = '0; bus_a.hit = 1'b0;
        bus_b.fire = 1'b0; bus_b.launch_x = '0; bus_b.launch_y = '0; bus_b.dir = '0; bus_b.hit = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        // Reset state
        check("rst_x", 32'(bus_a.Torpedo_X_Pos), 32'd320);
        check("rst_y", 32'(bus_a.Torpedo_Y_Pos), 32'd240);
        check("rst_stop", 32'(bus_a.torpedo_stop), 32'd1);
        check("rst_ready", 32'(bus_a.ready), 32'd1);
        check("rst_blast", 32'(bus_a.blast), 32'd0);
        check("rst_miss", 32'(bus_a.miss), 32'd0);

        // Launch upward, three frames
        launch_a(10'd100, 10'd400, 2'd3);
        check("up_launch_y", 32'(bus_a.Torpedo_Y_Pos), 32'd400);
        check("up_launch_ready", 32'(bus_a.ready), 32'd0);
        ticks(3);
        check("up_y", 32'(bus_a.Torpedo_Y_Pos), 32'd388);
        check("up_x", 32'(bus_a.Torpedo_X_Pos), 32'd100);
        check("up_stop", 32'(bus_a.torpedo_stop), 32'd0);
        check("up_ready", 32'(bus_a.ready), 32'd0);

        // Reset mid-flight at X = 200
        pulse_reset();
        launch_a(10'd196, 10'd100, 2'd0);
        ticks(1);
        check("mid_x", 32'(bus_a.Torpedo_X_Pos), 32'd200);
        pulse_reset();
        check("mid_rst_x", 32'(bus_a.Torpedo_X_Pos), 32'd320);
        check("mid_rst_y", 32'(bus_a.Torpedo_Y_Pos), 32'd240);
        check("mid_rst_stop", 32'(bus_a.torpedo_stop), 32'd1);
        check("mid_rst_ready", 32'(bus_a.ready), 32'd1);
        check("mid_rst_blast", 32'(bus_a.blast), 32'd0);
        check("mid_rst_miss", 32'(bus_a.miss), 32'd0);

        // Right boundary exit and cooldown
        launch_a(10'd630, 10'd100, 2'd0);
        ticks(1);
        check("rb_x1", 32'(bus_a.Torpedo_X_Pos), 32'd634);
        ticks(1);
        check("rb_x2", 32'(bus_a.Torpedo_X_Pos), 32'd638);
        ticks(1);
        check("rb_x3", 32'(bus_a.Torpedo_X_Pos), 32'd638);
        check("rb_miss", 32'(bus_a.miss), 32'd1);
        check("rb_stop", 32'(bus_a.torpedo_stop), 32'd1);
        @(negedge Clk);
        check("rb_miss_clr", 32'(bus_a.miss), 32'd0);
        ticks(29);
        check("rb_cd29_ready", 32'(bus_a.ready), 32'd0);
        ticks(1);
        check("rb_cd30_ready", 32'(bus_a.ready), 32'd1);

        // hit in IDLE is ignored
        @(negedge Clk) bus_a.hit = 1'b1;
        @(negedge Clk) bus_a.hit = 1'b0;
        @(negedge Clk);
        check("idle_hit_ready", 32'(bus_a.ready), 32'd1);
        check("idle_hit_blast", 32'(bus_a.blast), 32'd0);
        check("idle_hit_x", 32'(bus_a.Torpedo_X_Pos), 32'd638);

        // hit together with a tick, blast hold, cooldown
        launch_a(10'd146, 10'd200, 2'd0);
        ticks(1);
        check("bl_x0", 32'(bus_a.Torpedo_X_Pos), 32'd150);
        @(negedge Clk); frame_clk = 1'b1; bus_a.hit = 1'b1;
        @(negedge Clk); frame_clk = 1'b0; bus_a.hit = 1'b0;
        check("bl_hit_x", 32'(bus_a.Torpedo_X_Pos), 32'd150);
        check("bl_hit_blast", 32'(bus_a.blast), 32'd1);
        check("bl_hit_stop", 32'(bus_a.torpedo_stop), 32'd0);
        ticks(3);
        @(negedge Clk) bus_a.hit = 1'b1;
        @(negedge Clk) bus_a.hit = 1'b0;
        check("bl_rehit_blast", 32'(bus_a.blast), 32'd1);
        ticks(4);
        check("bl_t7_blast", 32'(bus_a.blast), 32'd1);
        check("bl_t7_stop", 32'(bus_a.torpedo_stop), 32'd0);
        check("bl_t7_x", 32'(bus_a.Torpedo_X_Pos), 32'd150);
        ticks(1);
        check("bl_t8_blast", 32'(bus_a.blast), 32'd0);
        check("bl_t8_stop", 32'(bus_a.torpedo_stop), 32'd1);
        check("bl_t8_ready", 32'(bus_a.ready), 32'd0);
        ticks(30);
        check("bl_cd_ready", 32'(bus_a.ready), 32'd1);

        // fire during FLYING is ignored
        launch_a(10'd300, 10'd300, 2'd0);
        launch_a(10'd10, 10'd10, 2'd1);
        check("ff_x", 32'(bus_a.Torpedo_X_Pos), 32'd300);
        check("ff_y", 32'(bus_a.Torpedo_Y_Pos), 32'd300);
        check("ff_ready", 32'(bus_a.ready), 32'd0);
        ticks(1);
        check("ff_step_x", 32'(bus_a.Torpedo_X_Pos), 32'd304);

        // Left boundary
        pulse_reset();
        launch_a(10'd4, 10'd50, 2'd1);
        ticks(1);
        check("lb_x1", 32'(bus_a.Torpedo_X_Pos), 32'd0);
        ticks(1);
        check("lb_x2", 32'(bus_a.Torpedo_X_Pos), 32'd0);
        check("lb_miss", 32'(bus_a.miss), 32'd1);

        // Bottom boundary, then fire held through cooldown
        pulse_reset();
        launch_a(10'd10, 10'd472, 2'd2);
        ticks(1);
        check("db_y1", 32'(bus_a.Torpedo_Y_Pos), 32'd476);
        ticks(1);
        check("db_y2", 32'(bus_a.Torpedo_Y_Pos), 32'd476);
        check("db_miss", 32'(bus_a.miss), 32'd1);
        check("db_stop", 32'(bus_a.torpedo_stop), 32'd1);
        bus_a.fire = 1'b1; bus_a.launch_x = 10'd20; bus_a.launch_y = 10'd30; bus_a.dir = 2'd0;
        ticks(30);
        check("hold_ready", 32'(bus_a.ready), 32'd1);
        @(negedge Clk);
        bus_a.fire = 1'b0;
        check("hold_launch_ready", 32'(bus_a.ready), 32'd0);
        check("hold_launch_x", 32'(bus_a.Torpedo_X_Pos), 32'd20);
        check("hold_launch_stop", 32'(bus_a.torpedo_stop), 32'd0);

        // Zero blast / zero cooldown instance
        @(negedge Clk);
        bus_b.fire = 1'b1; bus_b.launch_x = 10'd50; bus_b.launch_y = 10'd50; bus_b.dir = 2'd0;
        @(negedge Clk) bus_b.fire = 1'b0;
        check("z_launch_stop", 32'(bus_b.torpedo_stop), 32'd0);
        bus_b.hit = 1'b1;
        @(negedge Clk) bus_b.hit = 1'b0;
        check("z_hit_stop", 32'(bus_b.torpedo_stop), 32'd1);
        check("z_hit_blast", 32'(bus_b.blast), 32'd0);
        check("z_hit_ready", 32'(bus_b.ready), 32'd0);
        @(negedge Clk);
        check("z_ready", 32'(bus_b.ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
